// File: rtl/prng_pkg.sv
// prng_pkg
// Shared definitions for the PRNG slice scheduler slice:
//   - state_t     : scheduler states (WARMUP, CAPTURE, SERVE, HALT)
//   - PRNG_W      : width of the free-running PRNG word (256 bits)
//   - num_slices(): number of SLICE_W-wide slices carved out of one PRNG word
package prng_pkg;

    localparam int PRNG_W = 256;

    // Slice width used when the scheduler is built with its defaults.
    localparam int DEFAULT_SLICE_W = 32;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        CAPTURE = 2'd1,
        SERVE   = 2'd2,
        HALT    = 2'd3
    } state_t;

    // Number of slices one captured PRNG word provides.
    function automatic int num_slices(input int sliceW);
        return PRNG_W / sliceW;
    endfunction

    localparam int DEFAULT_NUM_SLICES = PRNG_W / DEFAULT_SLICE_W;

endpackage

// File: rtl/prng_rr_arb.sv
// prng_rr_arb
// Combinational round-robin arbiter. The search for a requester begins at
// start_i and wraps around; the first active request found wins.
// Ports:
//   req_i    [NUM_REQ-1:0] request levels
//   start_i  [PTR_W-1:0]   requester to consider first (one past the last winner)
//   gnt_o    [NUM_REQ-1:0] one-hot winner, all zero when no request is active
//   gntIdx_o [PTR_W-1:0]   binary index of the winner (0 when none)
module prng_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gntIdx_o
);

    logic             found;
    logic [PTR_W-1:0] candIdx;

    // Walk the requesters in priority order starting at start_i; the modulo
    // keeps the candidate inside 0..NUM_REQ-1 even for non power-of-two counts.
    always_comb begin
        gnt_o    = '0;
        gntIdx_o = '0;
        found    = 1'b0;
        candIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candIdx = PTR_W'((int'(start_i) + k) % NUM_REQ);
            if (!found && req_i[candIdx]) begin
                found          = 1'b1;
                gnt_o[candIdx] = 1'b1;
                gntIdx_o       = candIdx;
            end
        end
    end

endmodule

// File: rtl/prng_slice_sched.sv
// prng_slice_sched
// Hands out SLICE_W-wide slices of a free-running 256-bit PRNG word to
// NUM_REQ requesters in round-robin order. After reset the PRNG output is
// ignored for WARMUP_CYCLES cycles, then one word is captured and served
// slice by slice; once every slice has been granted a fresh word is captured.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   prng_output [255:0]        PRNG word, new value every cycle
//   req         [NUM_REQ-1:0]  request levels
//   gnt         [NUM_REQ-1:0]  one-hot grant pulse, rnd_data valid same cycle
//   rnd_data    [SLICE_W-1:0]  granted slice, holds when gnt is 0
//   rnd_avail   high while slices are being served
//   health_err  sticky PRNG health failure
// Configuration:
//   PRNG_SLICE_SCHED_HEALTH_EN  when defined, each captured word is rejected
//   if all-zero or equal to the previously captured word; the scheduler then
//   raises health_err and halts until reset. When undefined, health_err is 0.
module prng_slice_sched
    import prng_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SLICE_W       = 32,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [255:0]       prng_output,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SLICE_W-1:0] rnd_data,
    output logic               rnd_avail,
    output logic               health_err
);

    localparam int NSLICES = num_slices(SLICE_W);
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int PTR_W   = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [7:0]         warmCnt_q, warmCnt_d;
    logic [PRNG_W-1:0]  bufWord_q;
    logic               captureEn;
    logic [IDX_W-1:0]   sliceIdx_q, sliceIdx_d;
    logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SLICE_W-1:0] data_q, data_d;
    logic [NUM_REQ-1:0] arbGnt;
    logic [PTR_W-1:0]   arbIdx;

`ifdef PRNG_SLICE_SCHED_HEALTH_EN
    logic healthErr_q, healthErr_d;
    logic wordBad;

    // bufWord_q still holds the previously captured word while in CAPTURE,
    // so it doubles as the repeat-detection reference.
    assign wordBad = (prng_output == '0) || (prng_output == bufWord_q);
`endif

    prng_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req),
        .start_i  (rrPtr_q),
        .gnt_o    (arbGnt),
        .gntIdx_o (arbIdx)
    );

    // Next-state logic. Grants are decided here and registered, so the
    // grant pulse and its slice appear together one cycle after the decision.
    always_comb begin
        state_d    = state_q;
        warmCnt_d  = warmCnt_q;
        sliceIdx_d = sliceIdx_q;
        rrPtr_d    = rrPtr_q;
        gnt_d      = '0;
        data_d     = data_q;
        captureEn  = 1'b0;
`ifdef PRNG_SLICE_SCHED_HEALTH_EN
        healthErr_d = healthErr_q;
`endif
        case (state_q)
            WARMUP: begin
                if (warmCnt_q == 8'(WARMUP_CYCLES - 1)) begin
                    warmCnt_d = '0;
                    state_d   = CAPTURE;
                end else begin
                    warmCnt_d = warmCnt_q + 8'd1;
                end
            end
            CAPTURE: begin
                captureEn  = 1'b1;
                sliceIdx_d = '0;
`ifdef PRNG_SLICE_SCHED_HEALTH_EN
                if (wordBad) begin
                    healthErr_d = 1'b1;
                    state_d     = HALT;
                end else begin
                    state_d = SERVE;
                end
`else
                state_d = SERVE;
`endif
            end
            SERVE: begin
                if (|req) begin
                    gnt_d   = arbGnt;
                    data_d  = SLICE_W'(bufWord_q >> (int'(sliceIdx_q) * SLICE_W));
                    rrPtr_d = (arbIdx == PTR_W'(NUM_REQ - 1)) ? '0 : arbIdx + PTR_W'(1);
                    if (sliceIdx_q == IDX_W'(NSLICES - 1)) begin
                        sliceIdx_d = '0;
                        state_d    = CAPTURE;
                    end else begin
                        sliceIdx_d = sliceIdx_q + IDX_W'(1);
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    // State, counters and output registers; reset discards any buffered slices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WARMUP;
            warmCnt_q  <= '0;
            bufWord_q  <= '0;
            sliceIdx_q <= '0;
            rrPtr_q    <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            warmCnt_q  <= warmCnt_d;
            sliceIdx_q <= sliceIdx_d;
            rrPtr_q    <= rrPtr_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            if (captureEn) begin
                bufWord_q <= prng_output;
            end
        end
    end

`ifdef PRNG_SLICE_SCHED_HEALTH_EN
    // Sticky health flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            healthErr_q <= 1'b0;
        end else begin
            healthErr_q <= healthErr_d;
        end
    end

    assign health_err = healthErr_q;
`else
    assign health_err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign rnd_data  = data_q;
    assign rnd_avail = (state_q == SERVE);

endmodule

// File: tb/tb_prng_slice_sched.sv
// tb_prng_slice_sched
// Randomized self-checking bench for prng_slice_sched (NUM_REQ=4, SLICE_W=32,
// WARMUP_CYCLES=16). A behavioural model tracks the cycles remaining before a
// word is captured, a queue of undelivered slices and the round-robin start
// requester; every cycle the DUT outputs are compared against it.
// Honours PRNG_SLICE_SCHED_HEALTH_EN the same way as the design.
module tb_prng_slice_sched;

    localparam int NREQ    = 4;
    localparam int SW      = 32;
    localparam int WARM    = 16;
    localparam int NSLICE  = 256 / SW;

    logic            clk;
    logic            rst;
    logic [255:0]    prng_output;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   rnd_data;
    logic            rnd_avail;
    logic            health_err;

    int assertCount;
    int failCount;
    int edgeCnt;
    bit zeroMode;

    // Reference model state
    int              mWait;
    logic [SW-1:0]   mSlices[$];
    int              mPtr;
    bit              mHalted;
    logic [255:0]    mPrev;
    logic [NREQ-1:0] expGnt;
    logic [SW-1:0]   expData;
    bit              expAvail;
    bit              expHealth;

    prng_slice_sched #(
        .NUM_REQ       (NREQ),
        .SLICE_W       (SW),
        .WARMUP_CYCLES (WARM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prng_output (prng_output),
        .req         (req),
        .gnt         (gnt),
        .rnd_data    (rnd_data),
        .rnd_avail   (rnd_avail),
        .health_err  (health_err)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports each check
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] randWord();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Model after reset: WARM discarded cycles plus one capture cycle precede serving
    task automatic modelReset();
        mWait     = WARM + 1;
        mSlices.delete();
        mPtr      = 0;
        mHalted   = 0;
        mPrev     = '0;
        expGnt    = '0;
        expData   = '0;
        expAvail  = 0;
        expHealth = 0;
        edgeCnt   = 0;
    endtask

    // Model behaviour for one rising edge given the inputs present before it
    task automatic modelStep(input logic [NREQ-1:0] r, input logic [255:0] w);
        expGnt = '0;
        if (mHalted) begin
            expGnt = '0;
        end else if (mSlices.size() > 0) begin
            if (r != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (mPtr + k) % NREQ;
                    if (expGnt == '0 && r[c]) begin
                        expGnt  = NREQ'(1) << c;
                        mPtr    = (c + 1) % NREQ;
                    end
                end
                expData = mSlices.pop_front();
                if (mSlices.size() == 0) mWait = 1;
            end
        end else begin
            mWait--;
            if (mWait == 0) begin
`ifdef PRNG_SLICE_SCHED_HEALTH_EN
                if (w == '0 || w == mPrev) begin
                    mHalted   = 1;
                    expHealth = 1;
                end
`endif
                mPrev = w;
                if (!mHalted) begin
                    for (int s = 0; s < NSLICE; s++) mSlices.push_back(w[s*SW +: SW]);
                end
            end
        end
        expAvail = !mHalted && (mSlices.size() > 0);
    endtask

    // Advance one cycle: model update, edge, then compare outputs and drive a new PRNG word
    task automatic applyStimulus();
        if (rst) modelReset();
        else modelStep(req, prng_output);
        @(posedge clk);
        #1;
        if (!rst) edgeCnt++;
        checkOutput("gnt", 64'(gnt), 64'(expGnt));
        checkOutput("rnd_data", 64'(rnd_data), 64'(expData));
        checkOutput("rnd_avail", 64'(rnd_avail), 64'(expAvail));
        checkOutput("health_err", 64'(health_err), 64'(expHealth));
        prng_output = zeroMode ? '0 : randWord();
    endtask

    // Wait for the first grant after a reset release and check its timing and data
    task automatic checkFirstGrant(input string tag);
        bit found;
        int at;
        found = 0;
        at    = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus();
            if (gnt != '0) begin
                found = 1;
                at    = edgeCnt;
            end
        end
        checkOutput({tag, "_cycle"}, 64'(at), 64'd18);
        checkOutput({tag, "_data"}, 64'(rnd_data), 64'(mPrev[SW-1:0]));
    endtask

    // Run until the model has delivered `delivered` slices of the current word
    task automatic waitSlices(input string tag, input int delivered);
        bit found;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mWait == 0 && !mHalted && mSlices.size() == NSLICE - delivered) found = 1;
            else applyStimulus();
        end
        checkOutput({tag, "_reached"}, 64'(found), 64'd1);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        zeroMode    = 0;
        rst         = 1'b1;
        req         = '0;
        prng_output = randWord();
        modelReset();

        // Reset state
        repeat (3) applyStimulus();

        // First grant latency with a single requester
        rst = 1'b0;
        req = 4'b0001;
        checkFirstGrant("firstGnt");
        repeat (12) applyStimulus();

        // All requesters: round-robin order, 8 grants per 9 cycles
        req = 4'b1111;
        repeat (30) applyStimulus();

        // Requests dropped after slice 3 for 5 cycles, then resumed
        waitSlices("pause", 4);
        req = 4'b0000;
        repeat (5) applyStimulus();
        req = 4'b1111;
        repeat (12) applyStimulus();

        // Random request patterns
        for (int i = 0; i < 200; i++) begin
            req = NREQ'($urandom_range(0, 15));
            applyStimulus();
        end

        // Asynchronous reset in the middle of serving
        req = 4'b1111;
        waitSlices("midRst", 6);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst_gnt", 64'(gnt), 64'd0);
        checkOutput("asyncRst_data", 64'(rnd_data), 64'd0);
        checkOutput("asyncRst_avail", 64'(rnd_avail), 64'd0);
        checkOutput("asyncRst_health", 64'(health_err), 64'd0);
        modelReset();
        repeat (2) applyStimulus();
        rst = 1'b0;
        checkFirstGrant("afterRst");
        repeat (20) applyStimulus();

        // Constant all-zero PRNG word
        rst = 1'b1;
        repeat (2) applyStimulus();
        zeroMode    = 1;
        prng_output = '0;
        rst         = 1'b0;
        req         = 4'b1111;
        repeat (60) applyStimulus();
`ifdef PRNG_SLICE_SCHED_HEALTH_EN
        checkOutput("zeroWord_health", 64'(health_err), 64'd1);
`else
        checkOutput("zeroWord_health", 64'(health_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/prng_slice_sched.md
PRNG_SLICE_SCHED -- requirements
Module: prng_slice_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter SLICE_W, default 32: slice width; 256 divisible by SLICE_W.
REQ-003 SHALL have parameter WARMUP_CYCLES, default 16: cycles discarded after reset, 1..255.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port prng_output  input  256  free-running nlfsr_256 word, new value every cycle.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester request level.
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse, data valid same cycle.
REQ-009 SHALL have port rnd_data  output  SLICE_W  granted slice.
REQ-010 SHALL have port rnd_avail  output  1  high in SERVE state.
REQ-011 SHALL have port health_err  output  1  sticky PRNG health failure.

Function
REQ-012 SHALL implement states WARMUP, CAPTURE, SERVE, HALT.
REQ-013 WARMUP SHALL count WARMUP_CYCLES cycles, then enter CAPTURE; no grants.
REQ-014 CAPTURE SHALL last one cycle, latch prng_output into a 256-bit buffer, set slice index 0, enter SERVE; no grants.
REQ-015 SERVE SHALL issue at most one grant per cycle when any req bit is high.
REQ-016 Grant selection SHALL be round-robin, search starting at the requester after the last granted one; after reset, search starts at requester 0.
REQ-017 On grant, rnd_data SHALL equal buffer slice [idx*SLICE_W +: SLICE_W], registered, and gnt SHALL be high exactly that cycle.
REQ-018 Slice index SHALL increment per grant; the grant of the last slice (256/SLICE_W-1) SHALL move the state to CAPTURE next cycle.
REQ-019 With no req high in SERVE, state, index and pointer SHALL hold; gnt SHALL be 0.
REQ-020 Requests arriving during WARMUP/CAPTURE SHALL be served in SERVE with no loss while req held high.
REQ-021 No slice SHALL ever be delivered twice; sustained throughput SHALL be 8 grants per 9 cycles at SLICE_W=32.
REQ-022 rnd_data SHALL hold its last value when gnt is 0.

Reset
REQ-023 rst high SHALL immediately force state WARMUP, counters 0, index 0, pointer to requester 0, buffer 0.
REQ-024 During reset gnt, rnd_data, rnd_avail, health_err SHALL be 0.
REQ-025 rst asserted mid-SERVE SHALL discard remaining slices; warm-up restarts fully after release.

Configuration
REQ-026 Macro PRNG_SLICE_SCHED_HEALTH_EN SHALL enable the health check.
REQ-027 With macro: in CAPTURE, a word equal to the previous captured word or all-zero SHALL set health_err and enter HALT; HALT grants nothing until rst.
REQ-028 Without macro: no compare logic, no previous-word register, health_err tied 0, HALT unreachable.

Structure
REQ-029 Package prng_pkg SHALL hold the state enum, PRNG_W=256 and helper constant for slice count.
REQ-030 Round-robin logic SHALL be sub-module prng_rr_arb (req, last-grant pointer in; one-hot grant out).

Verification
REQ-031 Reset release, req=4'b0001 held, WARMUP_CYCLES=16 -> first gnt at cycle 18 after release, rnd_data = captured word bits [31:0].
REQ-032 req=4'b1111 held -> gnt order 0,1,2,3,0,1,2,3 carrying slices 0..7, then one idle cycle, repeat.
REQ-033 req toggled to 0 after slice 3 for 5 cycles, then reasserted -> next grant carries slice 4; no slice skipped or repeated.
REQ-034 rst pulsed during slice 5 -> all outputs 0 asynchronously; after release, 16-cycle warm-up, fresh capture, slice 0 first.
REQ-035 With PRNG_SLICE_SCHED_HEALTH_EN, prng_output forced constant 256'h0 -> health_err=1 after first CAPTURE, gnt stays 0 until rst.
REQ-036 Without macro, same stimulus -> health_err=0 and slices of 0 are granted normally.
